// File: rtl/jtframe_sdram_arb_if.sv
// rtl/jtframe_sdram_arb_if.sv - requester and core-side bus bundle for the SDRAM arbiter
// Ports (signals of the bundle):
//   requester side : downloading, ba_addr/ba_rd/ba_wr/ba0_din/ba0_din_m in,
//                    ba_ack/ba_dst/ba_dok/ba_rdy out,
//                    prog_addr/prog_ba/prog_rd/prog_we/prog_data/prog_mask in,
//                    prog_ack/prog_dst/prog_dok/prog_rdy out
//   core side      : cmd_rd/cmd_wr/cmd_ref/cmd_ba/cmd_addr/cmd_din/cmd_dqm out,
//                    core_ack/core_dst/core_dok/core_rdy in
//   slave modport  : arbiter view; master modport : environment view
interface jtframe_sdram_arb_if #(
    parameter int SDRAMW = 23
);
    logic                    downloading;
    logic [4*SDRAMW-1:0]     ba_addr;
    logic [3:0]              ba_rd;
    logic [3:0]              ba_wr;
    logic [15:0]             ba0_din;
    logic [1:0]              ba0_din_m;
    logic [3:0]              ba_ack;
    logic [3:0]              ba_dst;
    logic [3:0]              ba_dok;
    logic [3:0]              ba_rdy;
    logic [SDRAMW-1:0]       prog_addr;
    logic [1:0]              prog_ba;
    logic                    prog_rd;
    logic                    prog_we;
    logic [15:0]             prog_data;
    logic [1:0]              prog_mask;
    logic                    prog_ack;
    logic                    prog_dst;
    logic                    prog_dok;
    logic                    prog_rdy;
    logic                    cmd_rd;
    logic                    cmd_wr;
    logic                    cmd_ref;
    logic [1:0]              cmd_ba;
    logic [SDRAMW-1:0]       cmd_addr;
    logic [15:0]             cmd_din;
    logic [1:0]              cmd_dqm;
    logic                    core_ack;
    logic                    core_dst;
    logic                    core_dok;
    logic                    core_rdy;

    modport slave (
        input  downloading, ba_addr, ba_rd, ba_wr, ba0_din, ba0_din_m,
        input  prog_addr, prog_ba, prog_rd, prog_we, prog_data, prog_mask,
        input  core_ack, core_dst, core_dok, core_rdy,
        output ba_ack, ba_dst, ba_dok, ba_rdy,
        output prog_ack, prog_dst, prog_dok, prog_rdy,
        output cmd_rd, cmd_wr, cmd_ref, cmd_ba, cmd_addr, cmd_din, cmd_dqm
    );

    modport master (
        output downloading, ba_addr, ba_rd, ba_wr, ba0_din, ba0_din_m,
        output prog_addr, prog_ba, prog_rd, prog_we, prog_data, prog_mask,
        output core_ack, core_dst, core_dok, core_rdy,
        input  ba_ack, ba_dst, ba_dok, ba_rdy,
        input  prog_ack, prog_dst, prog_dok, prog_rdy,
        input  cmd_rd, cmd_wr, cmd_ref, cmd_ba, cmd_addr, cmd_din, cmd_dqm
    );
endinterface

// File: rtl/jtframe_sdram_arb.sv
// rtl/jtframe_sdram_arb.sv - shares one SDRAM command core between four banks, prog and refresh
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : jtframe_sdram_arb_if.slave (requester ports, command to core, core strobes)
// One transaction is in flight at a time. Bank requests are served round-robin,
// the prog port only while downloading, and a periodic refresh takes precedence
// over both whenever the arbiter is idle.
module jtframe_sdram_arb #(
    parameter int SDRAMW      = 23,
    parameter int REFRESH_CNT = 384
) (
    input  logic                       clk,
    input  logic                       rst,
    jtframe_sdram_arb_if.slave         bus
);
    localparam int CW = $clog2(REFRESH_CNT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REFRESH} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_ref_cnt;
    logic                r_ref_pend;
    logic [1:0]          r_ptr;
    logic [2:0]          r_owner;     // 0..3 bank, 4 prog
    logic                r_cmd_rd;
    logic                r_cmd_wr;
    logic                r_cmd_ref;
    logic [1:0]          r_cmd_ba;
    logic [SDRAMW-1:0]   r_cmd_addr;
    logic [15:0]         r_cmd_din;
    logic [1:0]          r_cmd_dqm;

    logic [3:0]          w_req;
    logic                w_bank_hit;
    logic [1:0]          w_bank_sel;
    logic [SDRAMW-1:0]   w_bank_addr;
    logic                w_bank_wr;
    logic [4:0]          w_owner_mask;
    logic [4:0]          w_ack_mask;
    logic                w_fwd;
    logic                w_unused;

    // Only bank 0 can write; the other write strobes are deliberately ignored.
    assign w_req    = bus.ba_rd | {3'b000, bus.ba_wr[0]};
    assign w_unused = ^bus.ba_wr[3:1];

    // Round-robin search starting just after the last granted bank. Walking from
    // the farthest candidate to the nearest lets the nearest one win.
    always_comb begin
        w_bank_hit = 1'b0;
        w_bank_sel = r_ptr;
        for (int i = 4; i >= 1; i--) begin
            if (w_req[r_ptr + 2'(i)]) begin
                w_bank_hit = 1'b1;
                w_bank_sel = r_ptr + 2'(i);
            end
        end
    end

    assign w_bank_addr = bus.ba_addr[32'(w_bank_sel) * SDRAMW +: SDRAMW];
    assign w_bank_wr   = (w_bank_sel == 2'd0) && bus.ba_wr[0];

    assign w_owner_mask = 5'b00001 << r_owner;
    assign w_ack_mask   = (r_state == ISSUE && bus.core_ack) ? w_owner_mask : 5'b00000;
    // Data strobes reach a requester only while its own transaction is in WAIT;
    // refresh strobes and anything arriving in other states are dropped.
    assign w_fwd        = (r_state == WAIT);

    assign bus.ba_ack   = w_ack_mask[3:0];
    assign bus.prog_ack = w_ack_mask[4];
    assign bus.ba_dst   = (w_fwd && bus.core_dst) ? w_owner_mask[3:0] : 4'b0000;
    assign bus.ba_dok   = (w_fwd && bus.core_dok) ? w_owner_mask[3:0] : 4'b0000;
    assign bus.ba_rdy   = (w_fwd && bus.core_rdy) ? w_owner_mask[3:0] : 4'b0000;
    assign bus.prog_dst = w_fwd && bus.core_dst && w_owner_mask[4];
    assign bus.prog_dok = w_fwd && bus.core_dok && w_owner_mask[4];
    assign bus.prog_rdy = w_fwd && bus.core_rdy && w_owner_mask[4];

    assign bus.cmd_rd   = r_cmd_rd;
    assign bus.cmd_wr   = r_cmd_wr;
    assign bus.cmd_ref  = r_cmd_ref;
    assign bus.cmd_ba   = r_cmd_ba;
    assign bus.cmd_addr = r_cmd_addr;
    assign bus.cmd_din  = r_cmd_din;
    assign bus.cmd_dqm  = r_cmd_dqm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ref_cnt  <= CW'(REFRESH_CNT - 1);
            r_ref_pend <= 1'b0;
            r_ptr      <= 2'd3;
            r_owner    <= 3'd0;
            r_cmd_rd   <= 1'b0;
            r_cmd_wr   <= 1'b0;
            r_cmd_ref  <= 1'b0;
            r_cmd_ba   <= 2'd0;
            r_cmd_addr <= '0;
            r_cmd_din  <= 16'd0;
            r_cmd_dqm  <= 2'd0;
        end else begin
            // The clear sits before the expiry so that an expiry on the same
            // edge as the refresh ack still leaves a new refresh pending.
            if (r_state == REFRESH && r_cmd_ref && bus.core_ack) begin
                r_ref_pend <= 1'b0;
            end
            if (r_ref_cnt == '0) begin
                r_ref_cnt  <= CW'(REFRESH_CNT - 1);
                r_ref_pend <= 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt - 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (r_ref_pend) begin
                        r_cmd_ref <= 1'b1;
                        r_state   <= REFRESH;
                    end else if (bus.downloading) begin
                        if (bus.prog_rd || bus.prog_we) begin
                            r_owner    <= 3'd4;
                            r_cmd_ba   <= bus.prog_ba;
                            r_cmd_addr <= bus.prog_addr;
                            r_cmd_din  <= bus.prog_data;
                            r_cmd_dqm  <= bus.prog_we ? bus.prog_mask : 2'b00;
                            r_cmd_wr   <= bus.prog_we;
                            r_cmd_rd   <= ~bus.prog_we;
                            r_state    <= ISSUE;
                        end
                    end else if (w_bank_hit) begin
                        r_owner    <= {1'b0, w_bank_sel};
                        r_ptr      <= w_bank_sel;
                        r_cmd_ba   <= w_bank_sel;
                        r_cmd_addr <= w_bank_addr;
                        r_cmd_din  <= bus.ba0_din;
                        r_cmd_dqm  <= w_bank_wr ? bus.ba0_din_m : 2'b00;
                        r_cmd_wr   <= w_bank_wr;
                        r_cmd_rd   <= ~w_bank_wr;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.core_ack) begin
                        r_cmd_rd <= 1'b0;
                        r_cmd_wr <= 1'b0;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.core_rdy) begin
                        r_state <= IDLE;
                    end
                end
                REFRESH: begin
                    // r_cmd_ref doubles as the "waiting for ack" phase flag.
                    if (r_cmd_ref) begin
                        if (bus.core_ack) begin
                            r_cmd_ref <= 1'b0;
                        end
                    end else if (bus.core_rdy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// tb/tb_jtframe_sdram_arb.sv - self-checking bench for jtframe_sdram_arb
module tb_jtframe_sdram_arb;
    localparam int SDRAMW = 23;
    localparam int RCNT   = 16;
    localparam logic [22:0] A0 = 23'h000100;
    localparam logic [22:0] A1 = 23'h111200;
    localparam logic [22:0] A2 = 23'h222300;
    localparam logic [22:0] A3 = 23'h333400;

    typedef struct {
        logic        dl;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [15:0] din;
        logic [1:0]  dinm;
        logic        prd;
        logic        pwe;
        logic [1:0]  pba;
        logic [15:0] pdata;
        logic [1:0]  pmask;
        logic [22:0] paddr;
        logic [4:0]  e_ack;
        logic [1:0]  e_ba;
        logic [22:0] e_addr;
        logic        e_wr;
        logic [15:0] e_din;
        logic [1:0]  e_dqm;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtframe_sdram_arb_if #(.SDRAMW(SDRAMW)) bus();

    jtframe_sdram_arb #(.SDRAMW(SDRAMW), .REFRESH_CNT(RCNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   model_en = 1'b1;
    bit   mon_en = 1'b0;
    int   ack_dly = 2;
    int   data_dly = 3;
    int   mph = 0;
    int   mcnt = 0;
    vec_t sb[$];
    vec_t vecs[14];
    logic [4:0] cur_mask = 5'b0;
    int   m_cnt = RCNT - 1;
    bit   m_pend = 1'b0;
    int   age = 0;
    int   ref_seen = 0;
    int   expiries = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic dl, input logic [3:0] rd, input logic [3:0] wr,
                                input logic [15:0] din, input logic [1:0] dinm,
                                input logic prd, input logic pwe, input logic [1:0] pba,
                                input logic [15:0] pdata, input logic [1:0] pmask,
                                input logic [22:0] paddr, input logic [4:0] e_ack,
                                input logic [1:0] e_ba, input logic [22:0] e_addr,
                                input logic e_wr, input logic [15:0] e_din, input logic [1:0] e_dqm);
        vec_t v;
        v.dl = dl; v.rd = rd; v.wr = wr; v.din = din; v.dinm = dinm;
        v.prd = prd; v.pwe = pwe; v.pba = pba; v.pdata = pdata; v.pmask = pmask; v.paddr = paddr;
        v.e_ack = e_ack; v.e_ba = e_ba; v.e_addr = e_addr; v.e_wr = e_wr; v.e_din = e_din; v.e_dqm = e_dqm;
        return v;
    endfunction

    task automatic drop_reqs();
        bus.ba_rd = 4'b0; bus.ba_wr = 4'b0; bus.prog_rd = 1'b0; bus.prog_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int ad, input int dd);
        bit got = 1'b0;
        ack_dly = ad; data_dly = dd;
        bus.downloading = v.dl; bus.ba_rd = v.rd; bus.ba_wr = v.wr;
        bus.ba0_din = v.din; bus.ba0_din_m = v.dinm;
        bus.prog_rd = v.prd; bus.prog_we = v.pwe; bus.prog_ba = v.pba;
        bus.prog_data = v.pdata; bus.prog_mask = v.pmask; bus.prog_addr = v.paddr;
        sb.push_back(v);
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            if ({bus.prog_ack, bus.ba_ack} != 5'b0) got = 1'b1;
        end
        chk("grant_within_budget", {63'b0, got}, 64'd1);
        if (!got && sb.size() > 0) void'(sb.pop_back());
        drop_reqs();
    endtask

    // Core model: ack after ack_dly cycles, then dst/dok/rdy on consecutive cycles.
    initial begin
        bus.core_ack = 1'b0; bus.core_dst = 1'b0; bus.core_dok = 1'b0; bus.core_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (model_en) begin
                bus.core_ack = 1'b0; bus.core_dst = 1'b0; bus.core_dok = 1'b0; bus.core_rdy = 1'b0;
                if (rst) begin
                    mph = 0;
                end else begin
                    case (mph)
                        0: if (bus.cmd_rd || bus.cmd_wr || bus.cmd_ref) begin
                               if (ack_dly == 0) begin
                                   bus.core_ack = 1'b1; mcnt = data_dly; mph = 2;
                               end else begin
                                   mcnt = ack_dly; mph = 1;
                               end
                           end
                        1: begin
                               mcnt--;
                               if (mcnt == 0) begin bus.core_ack = 1'b1; mcnt = data_dly; mph = 2; end
                           end
                        2: if (mcnt == 0) begin bus.core_dst = 1'b1; mph = 3; end else mcnt--;
                        3: begin bus.core_dok = 1'b1; mph = 4; end
                        default: begin bus.core_rdy = 1'b1; mph = 0; end
                    endcase
                end
            end else begin
                mph = 0;
            end
        end
    end

    // Monitor / scoreboard and refresh-timing model, sampled mid-cycle.
    initial begin
        vec_t e;
        logic [4:0] acks;
        bit nxt;
        bit ref_ack;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                acks = {bus.prog_ack, bus.ba_ack};
                chk("cmd_onehot", {63'b0, $countones({bus.cmd_rd, bus.cmd_wr, bus.cmd_ref}) <= 1}, 64'd1);
                chk("ack_onehot", {63'b0, $countones(acks) <= 1}, 64'd1);
                if (acks != 5'b0 || (bus.core_ack && (bus.cmd_rd || bus.cmd_wr))) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", {59'b0, acks}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("ack_vector", {59'b0, acks}, {59'b0, e.e_ack});
                        chk("cmd_ba", {62'b0, bus.cmd_ba}, {62'b0, e.e_ba});
                        chk("cmd_addr", {41'b0, bus.cmd_addr}, {41'b0, e.e_addr});
                        chk("cmd_rdwr", {62'b0, bus.cmd_wr, bus.cmd_rd}, {62'b0, e.e_wr, ~e.e_wr});
                        chk("cmd_dqm", {62'b0, bus.cmd_dqm}, {62'b0, e.e_dqm});
                        if (e.e_wr) chk("cmd_din", {48'b0, bus.cmd_din}, {48'b0, e.e_din});
                        cur_mask = e.e_ack;
                    end
                end else if (bus.core_ack && bus.cmd_ref) begin
                    cur_mask = 5'b0;
                end else begin
                    chk("no_stray_ack", {59'b0, acks}, 64'd0);
                end
                chk("dst_route", {59'b0, bus.prog_dst, bus.ba_dst}, {59'b0, bus.core_dst ? cur_mask : 5'b0});
                chk("dok_route", {59'b0, bus.prog_dok, bus.ba_dok}, {59'b0, bus.core_dok ? cur_mask : 5'b0});
                chk("rdy_route", {59'b0, bus.prog_rdy, bus.ba_rdy}, {59'b0, bus.core_rdy ? cur_mask : 5'b0});

                if (rst) begin
                    cur_mask = 5'b0;
                    m_cnt = RCNT - 1; m_pend = 1'b0; age = 0;
                end else begin
                    ref_ack = bus.cmd_ref && bus.core_ack;
                    if (ref_ack) begin
                        ref_seen++;
                        chk("ref_only_when_pending", {63'b0, m_pend}, 64'd1);
                        chk("ref_latency_ok", {63'b0, age <= 30}, 64'd1);
                    end
                    nxt = m_pend && !ref_ack;
                    if (m_cnt == 0) begin
                        expiries++;
                        if (model_en) chk("ref_not_absorbed", {63'b0, nxt}, 64'd0);
                        nxt = 1'b1;
                        m_cnt = RCNT - 1;
                    end else begin
                        m_cnt--;
                    end
                    m_pend = nxt;
                    if (m_pend && model_en) age++; else age = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.downloading = 1'b0;
        bus.ba_addr = {A3, A2, A1, A0};
        bus.ba0_din = 16'h0; bus.ba0_din_m = 2'b0;
        bus.prog_addr = '0; bus.prog_ba = 2'b0; bus.prog_data = 16'h0; bus.prog_mask = 2'b0;
        drop_reqs();

        vecs[0]  = mk(0, 4'b1111, 4'b0000, 16'h0, 2'b00, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b00001, 2'd0, A0, 0, 16'h0, 2'b00);
        vecs[1]  = mk(0, 4'b1111, 4'b0000, 16'h0, 2'b00, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b00010, 2'd1, A1, 0, 16'h0, 2'b00);
        vecs[2]  = mk(0, 4'b1111, 4'b0000, 16'h0, 2'b00, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b00100, 2'd2, A2, 0, 16'h0, 2'b00);
        vecs[3]  = mk(0, 4'b1111, 4'b0000, 16'h0, 2'b00, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b01000, 2'd3, A3, 0, 16'h0, 2'b00);
        vecs[4]  = mk(0, 4'b1111, 4'b0000, 16'h0, 2'b00, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b00001, 2'd0, A0, 0, 16'h0, 2'b00);
        vecs[5]  = mk(0, 4'b0100, 4'b0000, 16'h0, 2'b00, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b00100, 2'd2, A2, 0, 16'h0, 2'b00);
        vecs[6]  = mk(0, 4'b0000, 4'b0011, 16'hA55A, 2'b01, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b00001, 2'd0, A0, 1, 16'hA55A, 2'b01);
        vecs[7]  = mk(0, 4'b0001, 4'b0001, 16'h1234, 2'b10, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b00001, 2'd0, A0, 1, 16'h1234, 2'b10);
        vecs[8]  = mk(0, 4'b1000, 4'b0010, 16'h5678, 2'b11, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b01000, 2'd3, A3, 0, 16'h0, 2'b00);
        vecs[9]  = mk(1, 4'b0001, 4'b0000, 16'h0, 2'b00, 0, 1, 2'd3, 16'hBEEF, 2'b10, 23'h071234, 5'b10000, 2'd3, 23'h071234, 1, 16'hBEEF, 2'b10);
        vecs[10] = mk(1, 4'b1111, 4'b0000, 16'h0, 2'b00, 1, 0, 2'd1, 16'hCAFE, 2'b11, 23'h055AA0, 5'b10000, 2'd1, 23'h055AA0, 0, 16'h0, 2'b00);
        vecs[11] = mk(0, 4'b0001, 4'b0000, 16'h0, 2'b00, 0, 1, 2'd2, 16'hDEAD, 2'b01, 23'h012345, 5'b00001, 2'd0, A0, 0, 16'h0, 2'b00);
        vecs[12] = mk(0, 4'b0110, 4'b0000, 16'h0, 2'b00, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b00010, 2'd1, A1, 0, 16'h0, 2'b00);
        vecs[13] = mk(0, 4'b0110, 4'b0000, 16'h0, 2'b00, 0, 0, 2'd0, 16'h0, 2'b00, 23'h0, 5'b00100, 2'd2, A2, 0, 16'h0, 2'b00);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk("reset_cmd", {61'b0, bus.cmd_rd, bus.cmd_wr, bus.cmd_ref}, 64'd0);
        chk("reset_bus", {21'b0, bus.cmd_ba, bus.cmd_addr, bus.cmd_din, bus.cmd_dqm}, 64'd0);
        chk("reset_acks", {59'b0, bus.prog_ack, bus.ba_ack}, 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (i <= 4)      run_vec(vecs[i], 0, 0);
            else if (i == 5) run_vec(vecs[i], 2, 3);
            else             run_vec(vecs[i], $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Bank request while downloading without prog traffic: never served.
        repeat (15) @(negedge clk);
        bus.downloading = 1'b1; bus.ba_rd = 4'b0001;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (bus.cmd_rd || bus.cmd_wr) seen = 1'b1; end
        chk("dl_blocks_bank", {63'b0, seen}, 64'd0);
        drop_reqs(); bus.downloading = 1'b0;

        // prog request outside download: ignored.
        bus.prog_we = 1'b1;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (bus.cmd_rd || bus.cmd_wr) seen = 1'b1; end
        chk("prog_needs_dl", {63'b0, seen}, 64'd0);
        drop_reqs();

        repeat (15) @(negedge clk);
        chk("ref_issued", {63'b0, ref_seen > 0}, 64'd1);
        chk("ref_count", 64'(ref_seen), 64'(expiries - int'(m_pend)));

        // Reset in the middle of a bank-2 transaction.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; model_en = 1'b0;
        bus.ba_rd = 4'b0100;
        sb.push_back(vecs[5]);
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin @(negedge clk); if (bus.cmd_rd) seen = 1'b1; end
        chk("rst_pre_cmd", {63'b0, seen}, 64'd1);
        chk("rst_pre_ba", {62'b0, bus.cmd_ba}, 64'd2);
        @(posedge clk); #1; bus.core_ack = 1'b1;
        @(posedge clk); #1; bus.core_ack = 1'b0; bus.ba_rd = 4'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        bus.core_dst = 1'b1; bus.core_dok = 1'b1; bus.core_rdy = 1'b1;
        @(negedge clk);
        chk("rst_mid_cmd", {61'b0, bus.cmd_rd, bus.cmd_wr, bus.cmd_ref}, 64'd0);
        chk("rst_mid_bus", {21'b0, bus.cmd_ba, bus.cmd_addr, bus.cmd_din, bus.cmd_dqm}, 64'd0);
        chk("rst_mid_strobes", {44'b0, bus.prog_ack, bus.ba_ack, bus.prog_dst, bus.ba_dst,
                                bus.prog_dok, bus.ba_dok, bus.prog_rdy, bus.ba_rdy}, 64'd0);
        @(posedge clk); #1;
        bus.core_dst = 1'b0; bus.core_dok = 1'b0; bus.core_rdy = 1'b0;
        model_en = 1'b1;
        run_vec(vecs[0], 1, 1);

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end
endmodule
